// File: rtl/spi_demux_pkg.sv
// spi_demux_pkg: shared types and constants for the SPI chip-select demultiplexer.
//   demux_state_e : frame-tracking FSM states
//   MAX_CH        : largest supported device count (sets the channel index width)
//   CMD_W_DEF     : default command word width
package spi_demux_pkg;

    localparam int unsigned MAX_CH    = 16;
    localparam int unsigned CMD_W_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWaitLow,
        StActive,
        StLdac,
        StDrain
    } demux_state_e;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser with registered edge detect.
//   clk_ref  : system clock
//   sys_rstn : asynchronous active-low reset
//   din      : asynchronous input pin
//   lvl      : synchronised level
//   rise     : one-cycle pulse, STAGES+1 cycles after a pin rising edge
//   fall     : one-cycle pulse, STAGES+1 cycles after a pin falling edge
module sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_ref,
    input  logic sys_rstn,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], din};
            prev_q  <= chain_q[STAGES-1];
            rise_q  <= chain_q[STAGES-1] & ~prev_q;
            fall_q  <= ~chain_q[STAGES-1] & prev_q;
        end
    end

    assign lvl  = chain_q[STAGES-1];
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_cs_demux.sv
// spi_cs_demux: routes one host SPI port to one of NUM_CH devices chosen by a leading
// command word, and optionally fires an LDAC-style load strobe at end of frame.
//   clk_ref, sys_rstn       : system clock, asynchronous active-low reset
//   spi_csn/sck/sdi/sdo     : host SPI port (mode 0)
//   dev_csn, dev_ldac_n     : per-device chip-select and load strobe, active low
//   dev_sck, dev_sdi        : gated clock and data shared by all devices
//   dev_sdo                 : per-device data back to the host
//   sel_ch                  : selected channel index
//   busy                    : FSM not idle
//   err_cmd                 : one-cycle pulse on a bad, short or dropped frame
module spi_cs_demux
    import spi_demux_pkg::*;
#(
    parameter int unsigned       NUM_CH      = 4,
    parameter int unsigned       CMD_W       = CMD_W_DEF,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [NUM_CH-1:0] LDAC_MASK   = NUM_CH'(4'b0010),
    parameter int unsigned       LDAC_W      = 2
) (
    input  logic                      clk_ref,
    input  logic                      sys_rstn,
    input  logic                      spi_csn,
    input  logic                      spi_sck,
    input  logic                      spi_sdi,
    output logic                      spi_sdo,
    output logic [NUM_CH-1:0]         dev_csn,
    output logic                      dev_sck,
    output logic                      dev_sdi,
    input  logic [NUM_CH-1:0]         dev_sdo,
    output logic [NUM_CH-1:0]         dev_ldac_n,
    output logic [$clog2(MAX_CH)-1:0] sel_ch,
    output logic                      busy,
    output logic                      err_cmd
);

    localparam int unsigned SEL_W = $clog2(MAX_CH);

    logic csn_lvl, csn_rise, csn_fall;
    logic sck_lvl, sck_rise, sck_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
        .clk_ref  (clk_ref),
        .sys_rstn (sys_rstn),
        .din      (spi_csn),
        .lvl      (csn_lvl),
        .rise     (csn_rise),
        .fall     (csn_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk_ref  (clk_ref),
        .sys_rstn (sys_rstn),
        .din      (spi_sck),
        .lvl      (sck_lvl),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    // Same depth as the sck chain so the sampled bit lines up with the detected edge.
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   sdi_s;

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) sdi_sync_q <= '0;
        else           sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
    end
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    demux_state_e     state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CMD_W-2:0] shift_q, shift_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [3:0]       ldac_cnt_q, ldac_cnt_d;
    logic             drop_q, drop_d;
    logic             err_q, err_d;

    logic [CMD_W-1:0] cmd_word;
    logic             cmd_ok;
    logic             sdo_sel;
    logic             ldac_en;

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sel_q      <= '0;
            ldac_cnt_q <= '0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sel_q      <= sel_d;
            ldac_cnt_q <= ldac_cnt_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    // Command word including the bit being sampled on this sck edge.
    assign cmd_word = {shift_q, sdi_s};
    assign cmd_ok   = (cmd_word != '0) && (32'(cmd_word) <= NUM_CH);

    always_comb begin
        sdo_sel = 1'b0;
        ldac_en = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sdo_sel = dev_sdo[i];
                ldac_en = LDAC_MASK[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sel_d      = sel_q;
        ldac_cnt_d = ldac_cnt_q;
        drop_d     = drop_q;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (csn_fall) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                    drop_d    = 1'b0;
                end
            end
            StCmd: begin
                if (csn_rise) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (sck_rise) begin
                    shift_d = cmd_word[CMD_W-2:0];
                    if (bit_cnt_q == 4'(CMD_W - 1)) begin
                        if (cmd_ok) begin
                            sel_d   = SEL_W'(cmd_word - 1'b1);
                            state_d = StWaitLow;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDrain;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StWaitLow: begin
                if (csn_rise) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (sck_fall && !sck_lvl) begin
                    // Only open the gate while sck is low so dev_sck never sees a runt pulse.
                    state_d = StActive;
                end
            end
            StActive: begin
                if (csn_rise) begin
                    ldac_cnt_d = '0;
                    state_d    = ldac_en ? StLdac : StIdle;
                end
            end
            StLdac: begin
                if (csn_fall) drop_d = 1'b1;
                if (ldac_cnt_q == 4'(LDAC_W - 1)) begin
                    // A frame that started under the strobe is discarded once it ends.
                    if (drop_d) begin
                        err_d   = 1'b1;
                        state_d = StDrain;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    ldac_cnt_d = ldac_cnt_q + 4'd1;
                end
            end
            StDrain: begin
                if (csn_lvl) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dev_csn    = '1;
        dev_ldac_n = '1;
        dev_sck    = 1'b0;
        dev_sdi    = 1'b0;
        spi_sdo    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                if (state_q == StActive) dev_csn[i]    = 1'b0;
                if (state_q == StLdac)   dev_ldac_n[i] = 1'b0;
            end
        end
        // Data path is raw pins gated by state: no added latency once selected.
        if (state_q == StActive) begin
            dev_sck = spi_sck;
            dev_sdi = spi_sdi;
            spi_sdo = sdo_sel;
        end
    end

    assign sel_ch  = sel_q;
    assign busy    = (state_q != StIdle);
    assign err_cmd = err_q;

endmodule

// File: tb/tb_spi_cs_demux.sv
module tb_spi_cs_demux;

    localparam int         NCH    = 4;
    localparam int         CW     = 8;
    localparam int         SYNC   = 2;
    localparam int         LDW    = 2;
    localparam logic [3:0] LMASK  = 4'b0010;
    localparam int         H      = 8;

    logic       clk_ref = 1'b0;
    logic       sys_rstn;
    logic       spi_csn, spi_sck, spi_sdi, spi_sdo;
    logic [3:0] dev_csn, dev_sdo, dev_ldac_n;
    logic       dev_sck, dev_sdi;
    logic [3:0] sel_ch;
    logic       busy, err_cmd;

    spi_cs_demux #(
        .NUM_CH      (NCH),
        .CMD_W       (CW),
        .SYNC_STAGES (SYNC),
        .LDAC_MASK   (LMASK),
        .LDAC_W      (LDW)
    ) u_dut (
        .clk_ref    (clk_ref),
        .sys_rstn   (sys_rstn),
        .spi_csn    (spi_csn),
        .spi_sck    (spi_sck),
        .spi_sdi    (spi_sdi),
        .spi_sdo    (spi_sdo),
        .dev_csn    (dev_csn),
        .dev_sck    (dev_sck),
        .dev_sdi    (dev_sdi),
        .dev_sdo    (dev_sdo),
        .dev_ldac_n (dev_ldac_n),
        .sel_ch     (sel_ch),
        .busy       (busy),
        .err_cmd    (err_cmd)
    );

    always #5 clk_ref = ~clk_ref;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Running totals observed on the device side.
    int         cyc = 0;
    int         err_total = 0, sck_total = 0, quiet_viol = 0, excl_viol = 0;
    int         csn_low[4] = '{0, 0, 0, 0};
    int         ldac_low[4] = '{0, 0, 0, 0};
    int         csn_fall_cyc = 0, csn_rise_cyc = 0, ldac_fall_cyc = 0;
    logic [3:0] prev_csn = 4'hF, prev_ldac = 4'hF;
    logic [15:0] dev_rx = '0;
    bit         quiet = 1'b0;

    always @(posedge clk_ref) cyc <= cyc + 1;

    always @(posedge dev_sck) begin
        sck_total <= sck_total + 1;
        dev_rx    <= {dev_rx[14:0], dev_sdi};
    end

    always @(negedge clk_ref) begin
        if (sys_rstn) begin
            if (err_cmd) err_total <= err_total + 1;
            for (int i = 0; i < 4; i++) begin
                if (!dev_csn[i])    csn_low[i]  <= csn_low[i] + 1;
                if (!dev_ldac_n[i]) ldac_low[i] <= ldac_low[i] + 1;
            end
            if ($countones(~dev_csn) > 1 || $countones(~dev_ldac_n) > 1 ||
                (dev_csn != 4'hF && dev_ldac_n != 4'hF))
                excl_viol <= excl_viol + 1;
            if (quiet && (dev_csn != 4'hF || dev_sck || dev_sdi || spi_sdo))
                quiet_viol <= quiet_viol + 1;
            if (prev_csn == 4'hF && dev_csn != 4'hF)     csn_fall_cyc  <= cyc;
            if (prev_csn != 4'hF && dev_csn == 4'hF)     csn_rise_cyc  <= cyc;
            if (prev_ldac == 4'hF && dev_ldac_n != 4'hF) ldac_fall_cyc <= cyc;
            prev_csn  <= dev_csn;
            prev_ldac <= dev_ldac_n;
        end
    end

    // Host side and reference model state.
    logic [15:0] pat[4];
    int          t_cmd_fall = 0, t_csn_rise = 0;
    int          model_sel = 0;
    int          s_err, s_sck, s_quiet, s_excl;
    int          s_csn[4], s_ldac[4];

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_ref);
    endtask

    task automatic host_bit(input logic b);
        spi_sdi = b;
        wait_cyc(H);
        spi_sck = 1'b1;
        wait_cyc(H);
        spi_sck = 1'b0;
    endtask

    task automatic snap();
        s_err   = err_total;
        s_sck   = sck_total;
        s_quiet = quiet_viol;
        s_excl  = excl_viol;
        for (int i = 0; i < 4; i++) begin
            s_csn[i]  = csn_low[i];
            s_ldac[i] = ldac_low[i];
        end
    endtask

    task automatic host_frame(input logic [7:0] cmd, input int ncmd, input int ndata,
                              input logic [15:0] data, input bit quiet_all, input int tail,
                              output logic [15:0] rx);
        rx = '0;
        spi_csn = 1'b0;
        wait_cyc(H);
        quiet = 1'b1;
        for (int b = CW - 1; b >= CW - ncmd; b--) begin
            dev_sdo = 4'($urandom);
            host_bit(cmd[b]);
        end
        t_cmd_fall = cyc;
        quiet = quiet_all;
        for (int b = ndata - 1; b >= 0; b--) begin
            spi_sdi = data[b];
            for (int i = 0; i < 4; i++) dev_sdo[i] = pat[i][b];
            wait_cyc(H);
            rx = {rx[14:0], spi_sdo};
            spi_sck = 1'b1;
            wait_cyc(H);
            spi_sck = 1'b0;
        end
        wait_cyc(H);
        spi_csn = 1'b1;
        t_csn_rise = cyc;
        wait_cyc(tail);
        quiet = 1'b0;
    endtask

    // Expected channel from the command rules: a full word whose value is 1..NCH.
    function automatic int model_ch(input logic [7:0] cmd, input int ncmd);
        if (ncmd == CW && cmd >= 1 && cmd <= NCH) return int'(cmd) - 1;
        return -1;
    endfunction

    task automatic check_frame(input string tag, input int exp_ch, input int ndata,
                               input logic [15:0] data, input logic [15:0] rx,
                               input int exp_err, input bit chk_lat);
        logic [15:0] m;
        logic [3:0]  got_mask;
        logic [3:0]  exp_mask;
        logic [3:0]  lm;
        int          exp_ldac;
        lm = LMASK;
        m = (ndata >= 16) ? 16'hFFFF : 16'((32'd1 << ndata) - 1);
        for (int i = 0; i < 4; i++) got_mask[i] = (csn_low[i] - s_csn[i]) > 0;
        exp_mask = (exp_ch >= 0) ? 4'(1 << exp_ch) : 4'h0;
        if (exp_ch >= 0) model_sel = exp_ch;
        check({tag, "_err"}, err_total - s_err, exp_err);
        check({tag, "_csn"}, got_mask, exp_mask);
        check({tag, "_sck"}, sck_total - s_sck, (exp_ch >= 0) ? ndata : 0);
        for (int i = 0; i < 4; i++) begin
            exp_ldac = (i == exp_ch && lm[i]) ? LDW : 0;
            check($sformatf("%s_ldac%0d", tag, i), ldac_low[i] - s_ldac[i], exp_ldac);
        end
        check({tag, "_quiet"}, quiet_viol - s_quiet, 0);
        check({tag, "_excl"}, excl_viol - s_excl, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sel"}, sel_ch, model_sel);
        if (exp_ch >= 0) begin
            check({tag, "_host_rx"}, rx & m, pat[exp_ch] & m);
            check({tag, "_dev_rx"}, dev_rx & m, data & m);
            if (chk_lat) begin
                check({tag, "_csn_fall_lat"}, csn_fall_cyc - t_cmd_fall, SYNC + 2);
                check({tag, "_csn_rise_lat"}, csn_rise_cyc - t_csn_rise, SYNC + 2);
                if (lm[exp_ch])
                    check({tag, "_ldac_lat"},
                          (ldac_fall_cyc - csn_rise_cyc) inside {[0:1]}, 1);
            end
        end
    endtask

    logic [15:0] rx, d;
    int          ch, nc, nd;
    logic [7:0]  cmd;

    initial begin
        sys_rstn = 1'b0;
        spi_csn  = 1'b1;
        spi_sck  = 1'b0;
        spi_sdi  = 1'b0;
        dev_sdo  = '0;
        for (int i = 0; i < 4; i++) pat[i] = 16'($urandom);
        wait_cyc(3);
        #1;
        check("rst_csn", dev_csn, 4'hF);
        check("rst_ldac", dev_ldac_n, 4'hF);
        check("rst_pins", {dev_sck, dev_sdi, spi_sdo}, 3'b000);
        check("rst_ctl", {sel_ch, busy, err_cmd}, 6'd0);
        @(negedge clk_ref);
        sys_rstn = 1'b1;
        wait_cyc(10);

        // Load-strobed device, full 16-bit transfer.
        snap(); d = 16'($urandom);
        host_frame(8'h02, 8, 16, d, 1'b0, 30, rx);
        check_frame("ch1", 1, 16, d, rx, 0, 1'b1);

        // Read-back from device 0, which has no strobe.
        snap(); pat[0] = 16'hA5C3; d = 16'($urandom);
        host_frame(8'h01, 8, 16, d, 1'b0, 30, rx);
        check_frame("ch0", 0, 16, d, rx, 0, 1'b1);

        // Out-of-range commands.
        snap();
        host_frame(8'h00, 8, 16, 16'hFFFF, 1'b1, 30, rx);
        check_frame("cmd00", -1, 16, 16'hFFFF, rx, 1, 1'b0);
        snap();
        host_frame(8'h05, 8, 16, 16'hFFFF, 1'b1, 30, rx);
        check_frame("cmd05", -1, 16, 16'hFFFF, rx, 1, 1'b0);

        // Short frame: only 5 command bits.
        snap();
        host_frame(8'h02, 5, 0, 16'h0, 1'b1, 30, rx);
        check_frame("short", -1, 0, 16'h0, rx, 1, 1'b0);

        // Host starts a new frame while the load strobe is still low.
        snap(); d = 16'($urandom);
        host_frame(8'h02, 8, 16, d, 1'b0, 2, rx);
        host_frame(8'h03, 8, 8, 16'h00FF, 1'b1, 30, pat[3]);
        check_frame("drop", 1, 16, d, rx, 1, 1'b0);
        snap(); d = 16'($urandom);
        host_frame(8'h03, 8, 12, d, 1'b0, 30, rx);
        check_frame("after_drop", 2, 12, d, rx, 0, 1'b1);

        // Reset in the middle of a strobed transfer.
        snap();
        spi_csn = 1'b0;
        wait_cyc(H);
        for (int b = 7; b >= 0; b--) host_bit(cmd_bit(8'h02, b));
        host_bit(1'b0);
        host_bit(1'b1);
        spi_sdi = 1'b1;
        dev_sdo = 4'hF;
        wait_cyc(H);
        spi_sck = 1'b1;
        #1;
        check("pre_rst_csn", dev_csn, 4'b1101);
        check("pre_rst_sck", dev_sck, 1'b1);
        wait_cyc(2);
        sys_rstn = 1'b0;
        #1;
        check("mid_rst_csn", dev_csn, 4'hF);
        check("mid_rst_ldac", dev_ldac_n, 4'hF);
        check("mid_rst_pins", {dev_sck, dev_sdi, spi_sdo}, 3'b000);
        check("mid_rst_ctl", {sel_ch, busy, err_cmd}, 6'd0);
        spi_sck = 1'b0;
        spi_csn = 1'b1;
        wait_cyc(5);
        sys_rstn = 1'b1;
        wait_cyc(20);
        check("mid_rst_no_ldac", ldac_low[1] - s_ldac[1], 0);
        model_sel = 0;
        snap(); d = 16'($urandom);
        host_frame(8'h04, 8, 16, d, 1'b0, 30, rx);
        check_frame("post_rst", 3, 16, d, rx, 0, 1'b1);

        // Randomised frames against the command rules.
        for (int n = 0; n < 14; n++) begin
            for (int i = 0; i < 4; i++) pat[i] = 16'($urandom);
            cmd = 8'($urandom_range(0, 6));
            nc  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : CW;
            ch  = model_ch(cmd, nc);
            nd  = (nc < CW) ? 0 : int'($urandom_range(1, 16));
            d   = 16'($urandom);
            snap();
            host_frame(cmd, nc, nd, d, (ch < 0), 30, rx);
            check_frame($sformatf("rnd%0d", n), ch, nd, d, rx, (ch < 0) ? 1 : 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic cmd_bit(input logic [7:0] c, input int b);
        return c[b];
    endfunction

endmodule
